// File: rtl/psum_bram_accum_ctrl.sv
// PL-side psum BRAM controller: read-modify-write accumulate of partial sums
// into a single-port BRAM, plus a zero-fill sequencer for a word range.
module psum_bram_accum_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned SAT        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
    input  logic                  i_psum_vld,
    input  logic                  i_psum_first,
    input  logic [ADDR_WIDTH-1:0] i_psum_addr,
    input  logic [DATA_WIDTH-1:0] i_psum_dat,
    output logic                  o_psum_rdy,
    input  logic                  i_clr_start,
    input  logic [ADDR_WIDTH-1:0] i_clr_base,
    input  logic [ADDR_WIDTH-1:0] i_clr_len,
    output logic                  o_clr_done,
    output logic                  o_busy,
    output logic                  o_ovf,
    output logic                  o_abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idat,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    output logic [NUM_BYTE-1:0]   mem_wren,
    output logic                  mem_enb,
    output logic                  mem_rst
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StClr  = 3'd4;

    localparam int unsigned MSB   = DATA_WIDTH - 1;
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;      // psum word index or next clear index
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;      // clear words still to issue
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_idat_q, mem_idat_d;
    logic [NUM_BYTE-1:0]   mem_wren_q, mem_wren_d;
    logic                  mem_enb_q, mem_enb_d;
    logic                  clr_done_q, clr_done_d;
    logic                  ovf_q, ovf_d;
    logic                  abort_q, abort_d;

    logic                  psenb;
    logic [DATA_WIDTH-1:0] sum_raw;
    logic [DATA_WIDTH-1:0] sat_val;
    logic [DATA_WIDTH-1:0] sum_res;
    logic                  add_ovf;
    logic                  unused_conf;

    assign psenb       = i_conf_ctrl[0];
    assign unused_conf = ^i_conf_ctrl[REG_WIDTH-1:1];

    function automatic logic [ADDR_WIDTH-1:0] word_to_byte(input logic [ADDR_WIDTH-1:0] w);
        return w << 2;
    endfunction

    // Signed accumulate with overflow detect and optional clamp
    always_comb begin
        sum_raw = mem_odat + dat_q;
        add_ovf = (mem_odat[MSB] == dat_q[MSB]) && (sum_raw[MSB] != mem_odat[MSB]);
        sat_val = mem_odat[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        sum_res = ((SAT != 0) && add_ovf) ? sat_val : sum_raw;
    end

    // Next-state and registered BRAM bus; bus is computed for the state being entered
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        dat_d      = dat_q;
        cnt_d      = cnt_q;
        mem_addr_d = '0;
        mem_idat_d = '0;
        mem_wren_d = '0;
        mem_enb_d  = 1'b0;
        clr_done_d = 1'b0;
        ovf_d      = ovf_q;
        abort_d    = abort_q;

        case (state_q)
            StIdle: begin
                if (!psenb) begin
                    if (i_clr_start) begin
                        if (i_clr_len == '0) begin
                            clr_done_d = 1'b1;
                        end else begin
                            state_d    = StClr;
                            mem_enb_d  = 1'b1;
                            mem_wren_d = {NUM_BYTE{1'b1}};
                            mem_addr_d = word_to_byte(i_clr_base);
                            idx_d      = i_clr_base + ADDR_WIDTH'(1);
                            rem_d      = i_clr_len - ADDR_WIDTH'(1);
                        end
                    end else if (i_psum_vld) begin
                        idx_d      = i_psum_addr;
                        dat_d      = i_psum_dat;
                        mem_enb_d  = 1'b1;
                        mem_addr_d = word_to_byte(i_psum_addr);
                        if (i_psum_first) begin
                            state_d    = StWr;
                            mem_wren_d = {NUM_BYTE{1'b1}};
                            mem_idat_d = i_psum_dat;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
            end
            StRd: begin
                state_d = StWait;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d    = StWr;
                    mem_enb_d  = 1'b1;
                    mem_wren_d = {NUM_BYTE{1'b1}};
                    mem_addr_d = word_to_byte(idx_q);
                    mem_idat_d = sum_res;
                    ovf_d      = ovf_q | add_ovf;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWr: begin
                state_d = StIdle;
            end
            StClr: begin
                if (rem_q == '0) begin
                    state_d    = StIdle;
                    clr_done_d = 1'b1;
                end else begin
                    mem_enb_d  = 1'b1;
                    mem_wren_d = {NUM_BYTE{1'b1}};
                    mem_addr_d = word_to_byte(idx_q);
                    idx_d      = idx_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // PS taking the port back kills any in-flight operation
        if ((state_q != StIdle) && psenb) begin
            state_d    = StIdle;
            mem_enb_d  = 1'b0;
            mem_wren_d = '0;
            mem_addr_d = '0;
            mem_idat_d = '0;
            clr_done_d = 1'b0;
            ovf_d      = ovf_q;
            abort_d    = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            rem_q      <= '0;
            dat_q      <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_idat_q <= '0;
            mem_wren_q <= '0;
            mem_enb_q  <= 1'b0;
            clr_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            dat_q      <= dat_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_idat_q <= mem_idat_d;
            mem_wren_q <= mem_wren_d;
            mem_enb_q  <= mem_enb_d;
            clr_done_q <= clr_done_d;
            ovf_q      <= ovf_d;
            abort_q    <= abort_d;
        end
    end

    assign o_psum_rdy = (state_q == StIdle) & ~psenb & ~i_clr_start & ~rst;
    assign o_busy     = (state_q != StIdle);
    assign o_clr_done = clr_done_q;
    assign o_ovf      = ovf_q;
    assign o_abort    = abort_q;
    assign mem_addr   = mem_addr_q;
    assign mem_idat   = mem_idat_q;
    assign mem_wren   = mem_wren_q;
    assign mem_enb    = mem_enb_q;
    assign mem_rst    = 1'b0;

endmodule
